// File: rtl/inst_mem_responder.sv
// Instruction memory responder: single-outstanding fetch with fixed wait states,
// abort/flush support and a program-load write port.
module inst_mem_responder #(
    parameter int ADDRESS_LEN     = 32,
    parameter int INSTRUCTION_LEN = 32,
    parameter int DEPTH           = 256,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    input  logic [ADDRESS_LEN-1:0]     addr_in,
    input  logic                       abort_in,
    input  logic                       load_en_in,
    input  logic [ADDRESS_LEN-1:0]     load_addr_in,
    input  logic [INSTRUCTION_LEN-1:0] load_data_in,
    output logic                       ready_out,
    output logic                       valid_out,
    output logic [INSTRUCTION_LEN-1:0] rdata_out,
    output logic                       addr_err_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                     state, state_next;
    logic [3:0]                 cnt, cnt_next;
    logic [ADDRESS_LEN-1:0]     addr_q, addr_next;
    logic [INSTRUCTION_LEN-1:0] mem [DEPTH];
    logic                       fetch_ok;

    function automatic logic addr_ok(input logic [ADDRESS_LEN-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < ADDRESS_LEN'(DEPTH));
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            addr_q <= addr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = addr_q;
        unique case (state)
            IDLE: begin
                if (req_in && !abort_in) begin
                    addr_next  = addr_in;
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (abort_in) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    // counter still holds the pre-decrement value, so 1 means last wait cycle
                    cnt_next = cnt - 4'd1;
                    if (cnt == 4'd1) state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Memory is deliberately not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (load_en_in && addr_ok(load_addr_in))
            mem[load_addr_in[IDX_W+1:2]] <= load_data_in;
    end

    assign fetch_ok     = addr_ok(addr_q);
    assign ready_out    = (state == IDLE);
    assign valid_out    = (state == RESP) && !abort_in;
    assign addr_err_out = (state == RESP) && !fetch_ok;
    assign rdata_out    = ((state == RESP) && fetch_ok) ? mem[addr_q[IDX_W+1:2]] : '0;

endmodule
